// File: rtl/tm_sr_pkg.sv
// Shared types and helpers for the TMIIa shift-register responder.
// Optional length check enabled by defining TM_SR_LENCHECK_EN.
package tm_sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } sr_state_e;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic int out_idx(input bit dir, input int width);
    return dir ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/tm_sr_sync.sv
// N-stage input synchronizer with one-cycle rise/fall pulses.
// Pulses are decoded from the last two synchronized samples.
module tm_sr_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sh;
  logic         prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh   <= {sh[N-2:0], d};
      prev <= sh[N-1];
    end
  end

  assign q    = sh[N-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/tm_sr_responder.sv
// Chip-side model of the TMIIa config shift register for SR loopback.
// Define TM_SR_LENCHECK_EN to build the sticky bit-count check (len_err).
module tm_sr_responder
  import tm_sr_pkg::*;
#(
  parameter int WIDTH           = 170,
  parameter int CNT_WIDTH       = 8,
  parameter int SHIFT_DIRECTION = 1,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sr_clk,
  input  logic             sr_din,
  input  logic             sr_load,
  output logic             sr_dout,
  output logic [WIDTH-1:0] cfg,
  output logic             cfg_valid,
  output logic             busy,
  output logic             len_err
);

  localparam int OUT_IDX = out_idx(SHIFT_DIRECTION != 0, WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic clk_q, clk_rise, clk_fall;
  logic din_q, din_rise, din_fall;
  logic load_q, load_rise, load_fall;

  tm_sr_sync #(.N(SYNC_STAGES)) u_sync_clk (
    .clk  (clk),
    .rst  (rst),
    .d    (sr_clk),
    .q    (clk_q),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  tm_sr_sync #(.N(SYNC_STAGES)) u_sync_din (
    .clk  (clk),
    .rst  (rst),
    .d    (sr_din),
    .q    (din_q),
    .rise (din_rise),
    .fall (din_fall)
  );

  tm_sr_sync #(.N(SYNC_STAGES)) u_sync_load (
    .clk  (clk),
    .rst  (rst),
    .d    (sr_load),
    .q    (load_q),
    .rise (load_rise),
    .fall (load_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{clk_q, din_rise, din_fall, load_q, load_fall};

  sr_state_e            state;
  logic [CNT_WIDTH-1:0] bit_cnt;
  logic [WIDTH-1:0]     chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      chain     <= '0;
      cfg       <= '0;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
      sr_dout   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (clk_rise) begin
        if (SHIFT_DIRECTION != 0)
          chain <= {chain[WIDTH-2:0], din_q};
        else
          chain <= {din_q, chain[WIDTH-1:1]};
      end
      // Readback moves only on falling edges so it is settled at the next rise.
      if (clk_fall)
        sr_dout <= chain[OUT_IDX];
      unique case (state)
        ST_IDLE: begin
          if (load_rise) begin
            state <= ST_COMMIT;
            if (clk_rise)
              bit_cnt <= CNT_WIDTH'(1);
          end else if (clk_rise) begin
            state   <= ST_SHIFT;
            bit_cnt <= CNT_WIDTH'(1);
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (clk_rise && bit_cnt != CNT_MAX)
            bit_cnt <= bit_cnt + 1'b1;
          if (load_rise) begin
            state <= ST_COMMIT;
            busy  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          cfg       <= chain;
          cfg_valid <= 1'b1;
          if (clk_rise) begin
            state   <= ST_SHIFT;
            bit_cnt <= CNT_WIDTH'(1);
            busy    <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TM_SR_LENCHECK_EN
  localparam logic [CNT_WIDTH-1:0] WIDTH_CNT = CNT_WIDTH'(WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      len_err <= 1'b0;
    else if (state == ST_COMMIT && bit_cnt != WIDTH_CNT)
      len_err <= 1'b1;
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_tm_sr_responder.sv
// Directed bench for tm_sr_responder: shift, readback, commit, length check, reset.
// Expected values are hand-derived patterns; MSB-first shifting.
module tb_tm_sr_responder;

  localparam int W = 170;

  logic         clk;
  logic         rst;
  logic         sr_clk;
  logic         sr_din;
  logic         sr_load;
  logic         sr_dout;
  logic [W-1:0] cfg;
  logic         cfg_valid;
  logic         busy;
  logic         len_err;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  tm_sr_responder dut (
    .clk       (clk),
    .rst       (rst),
    .sr_clk    (sr_clk),
    .sr_din    (sr_din),
    .sr_load   (sr_load),
    .sr_dout   (sr_dout),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .len_err   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (cfg_valid) vcnt <= vcnt + 1;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_word(input  logic [W-1:0] w,
                           input  int           n,
                           input  bit           load_last,
                           output logic [W-1:0] rb);
    rb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sr_din = w[W-1-i];
      repeat (4) @(negedge clk);
      rb[W-1-i] = sr_dout;
      sr_clk = 1'b1;
      if (load_last && i == n - 1) sr_load = 1'b1;
      repeat (8) @(negedge clk);
      sr_clk  = 1'b0;
      sr_load = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    sr_load = 1'b1;
    repeat (8) @(negedge clk);
    sr_load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [W-1:0] pat_a, pat_b, pat_d, rb;
  logic         len_exp;
  int           v0;

  initial begin
`ifdef TM_SR_LENCHECK_EN
    len_exp = 1'b1;
`else
    len_exp = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      pat_a[i] = (i % 2) == 1;
      pat_b[i] = (i % 3) == 0;
    end
    pat_d = ~pat_a;

    rst = 1'b1;
    sr_clk = 1'b0;
    sr_din = 1'b0;
    sr_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg", cfg, '0);
    chk("rst_dout", W'(sr_dout), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_valid", W'(cfg_valid), '0);
    chk("rst_len", W'(len_err), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // pattern A, full length
    v0 = vcnt;
    send_word(pat_a, W, 1'b0, rb);
    chk("a_busy", W'(busy), W'(1));
    chk("a_rb_zero", rb, '0);
    pulse_load();
    chk("a_cfg", cfg, pat_a);
    chk("a_valid_cnt", W'(vcnt - v0), W'(1));
    chk("a_busy_after", W'(busy), '0);
    chk("a_len", W'(len_err), '0);

    // pattern B, readback must be A
    v0 = vcnt;
    send_word(pat_b, W, 1'b0, rb);
    chk("b_readback", rb, pat_a);
    pulse_load();
    chk("b_cfg", cfg, pat_b);
    chk("b_valid_cnt", W'(vcnt - v0), W'(1));
    chk("b_len", W'(len_err), '0);

    // 169 zero bits: chain keeps B[0] at the top
    send_word('0, W - 1, 1'b0, rb);
    pulse_load();
    chk("short_cfg", cfg, {pat_b[0], {(W-1){1'b0}}});
    chk("short_len", W'(len_err), W'(len_exp));

    // load coincident with last rise
    v0 = vcnt;
    send_word(pat_d, W, 1'b1, rb);
    chk("coinc_cfg", cfg, pat_d);
    chk("coinc_valid_cnt", W'(vcnt - v0), W'(1));
    chk("coinc_len_sticky", W'(len_err), W'(len_exp));

    // reset mid-shift
    send_word(pat_b, 50, 1'b0, rb);
    chk("mid_busy", W'(busy), W'(1));
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("mid_rst_cfg", cfg, '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_dout", W'(sr_dout), '0);
    chk("mid_rst_len", W'(len_err), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // load with zero bits in IDLE still commits
    v0 = vcnt;
    pulse_load();
    chk("idle_valid_cnt", W'(vcnt - v0), W'(1));
    chk("idle_cfg", cfg, '0);
    chk("idle_len", W'(len_err), W'(len_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
